// File: rtl/sys_arbiter.sv
// sys_arbiter: two-master arbiter for a shared system memory port with burst reads and single-beat writes.
// Optional macro ARB_RR_EN: simultaneous requests go to the master not granted last (default: fixed M1 priority).
module sys_arbiter #(
   parameter int BURST_LEN = 16,
   parameter int CNT_W     = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        M0Strobe,
   input  logic        M0RW,
   input  logic [31:0] M0Address,
   input  logic [31:0] M0Data_out,
   output logic [31:0] M0Data_in,
   output logic        M0Ready,
   input  logic        M1Strobe,
   input  logic        M1RW,
   input  logic [31:0] M1Address,
   input  logic [31:0] M1Data_out,
   output logic [31:0] M1Data_in,
   output logic        M1Ready,
   output logic        SysStrobe,
   output logic        SysRW,
   output logic [31:0] SysAddress,
   output logic [31:0] SysData_in,
   input  logic [31:0] SysData_out,
   input  logic        SysReady,
   output logic        Busy
);
   typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W:0]   tgt_q, tgt_d;
   logic             sel0, sel1, pick1, g_strobe, last_beat;
`ifdef ARB_RR_EN
   logic             last_q, last_d;
   assign pick1 = M1Strobe & (~M0Strobe | ~last_q);
`else
   assign pick1 = M1Strobe;
`endif
   assign sel0      = state_q == GNT0;
   assign sel1      = state_q == GNT1;
   assign g_strobe  = sel1 ? M1Strobe : M0Strobe;
   assign last_beat = {1'b0, cnt_q} == tgt_q - 1'b1;
   // Next state, beat counter and beat target; the target is one bit wider so a full burst fits.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tgt_d   = tgt_q;
`ifdef ARB_RR_EN
      last_d  = last_q;
`endif
      case (state_q)
         IDLE: if (M0Strobe | M1Strobe) begin
            state_d = pick1 ? GNT1 : GNT0;
            tgt_d   = (pick1 ? M1RW : M0RW) ? (CNT_W+1)'(BURST_LEN) : (CNT_W+1)'(1);
            cnt_d   = '0;
`ifdef ARB_RR_EN
            last_d  = pick1;
`endif
         end
         GNT0, GNT1: if (!g_strobe) begin
            state_d = IDLE;
            cnt_d   = '0;
         end else if (SysReady) begin
            state_d = last_beat ? IDLE : state_q;
            cnt_d   = last_beat ? '0 : cnt_q + 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end
   // State registers with asynchronous active-low reset.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         tgt_q   <= '0;
`ifdef ARB_RR_EN
         last_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tgt_q   <= tgt_d;
`ifdef ARB_RR_EN
         last_q  <= last_d;
`endif
      end
   end
   assign SysStrobe  = sel1 ? M1Strobe   : sel0 ? M0Strobe   : 1'b0;
   assign SysRW      = sel1 ? M1RW       : sel0 ? M0RW       : 1'b1;
   assign SysAddress = sel1 ? M1Address  : sel0 ? M0Address  : '0;
   assign SysData_in = sel1 ? M1Data_out : sel0 ? M0Data_out : '0;
   assign M0Ready    = sel0 & SysReady;
   assign M1Ready    = sel1 & SysReady;
   assign M0Data_in  = SysData_out;
   assign M1Data_in  = SysData_out;
   assign Busy       = state_q != IDLE;
endmodule
